// File: rtl/alu_issue.sv
// alu_issue -- ID/EX issue stage in front of the execute-stage ALU.
//
// Decodes one RV32I instruction per accepted transfer into an ALU
// operation code plus its two 32-bit operands, and registers the result
// behind a valid/ready handshake. A main register (M) drives the outputs
// and a one-entry skid register (S) absorbs the single extra transfer
// that can arrive while in_ready is still high during a stall. This keeps
// in_ready registered without losing throughput.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous kill of held and incoming instructions
//   in_valid/ready    upstream handshake (in_ready is a register)
//   in_instr, in_pc   raw instruction and its PC
//   in_rs1/rs2_data   register-file read values
//   out_valid/ready   downstream handshake
//   alu_ctrl          ALU operation code
//   alu_datain1/2     ALU operands
//   out_rd            destination register (instr[11:7])
//   out_wb_en         result is written back (OP, OP-IMM, LUI, AUIPC)
//   out_branch        conditional branch
//   out_funct3        instr[14:12], passed through
//   out_illegal       unsupported opcode/funct combination
`timescale 1ns/1ps

module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] alu_datain1,
  output logic [31:0] alu_datain2,
  output logic [4:0]  out_rd,
  output logic        out_wb_en,
  output logic        out_branch,
  output logic [2:0]  out_funct3,
  output logic        out_illegal
);

  // ALU operation codes, shared with the alu block.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  // Decoded fields carried through M and S. All-zero is the reset value
  // (ALU_ADD is zero), so one '0 clears the whole entry.
  typedef struct packed {
    logic        illegal;
    logic [2:0]  funct3;
    logic        branch;
    logic        wb_en;
    logic [4:0]  rd;
    logic [31:0] d2;
    logic [31:0] d1;
    logic [3:0]  ctrl;
  } issue_t;

  // ---------------------------------------------------------------------
  // Decode (combinational, input side)
  // ---------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic [31:0] shamt;
  logic [3:0]  base_ctrl;
  issue_t      dec;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign shamt  = {27'b0, in_instr[24:20]};

  // funct3 map shared by OP and OP-IMM; the SUB/SRA alternates are
  // layered on top per opcode.
  always_comb begin
    base_ctrl = ALU_ADD;
    case (funct3)
      3'b000: base_ctrl = ALU_ADD;
      3'b001: base_ctrl = ALU_SLL;
      3'b010: base_ctrl = ALU_SLT;
      3'b011: base_ctrl = ALU_SLTU;
      3'b100: base_ctrl = ALU_XOR;
      3'b101: base_ctrl = ALU_SRL;
      3'b110: base_ctrl = ALU_OR;
      default: base_ctrl = ALU_AND;
    endcase
  end

  always_comb begin
    dec        = '0;
    dec.rd     = in_instr[11:7];
    dec.funct3 = funct3;
    case (opcode)
      OPC_OP: begin
        dec.d1    = in_rs1_data;
        dec.d2    = in_rs2_data;
        dec.wb_en = 1'b1;
        dec.ctrl  = base_ctrl;
        if (funct7 == FUNCT7_ALT) begin
          if (funct3 == 3'b000) begin
            dec.ctrl = ALU_SUB;
          end else if (funct3 == 3'b101) begin
            dec.ctrl = ALU_SRA;
          end else begin
            dec.illegal = 1'b1;
          end
        end else if (funct7 != 7'b0) begin
          dec.illegal = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec.d1    = in_rs1_data;
        dec.d2    = imm_i;
        dec.wb_en = 1'b1;
        dec.ctrl  = base_ctrl;
        // Shifts take only the 5-bit shamt; the upper immediate bits
        // act as funct7 and must be a recognised pattern.
        if (funct3 == 3'b001) begin
          dec.d2      = shamt;
          dec.illegal = (funct7 != 7'b0);
        end else if (funct3 == 3'b101) begin
          dec.d2      = shamt;
          dec.ctrl    = in_instr[30] ? ALU_SRA : ALU_SRL;
          dec.illegal = (funct7 != 7'b0) && (funct7 != FUNCT7_ALT);
        end
      end
      OPC_LUI: begin
        dec.d2    = imm_u;
        dec.wb_en = 1'b1;
      end
      OPC_AUIPC: begin
        dec.d1    = in_pc;
        dec.d2    = imm_u;
        dec.wb_en = 1'b1;
      end
      OPC_BRANCH: begin
        dec.d1     = in_rs1_data;
        dec.d2     = in_rs2_data;
        dec.branch = 1'b1;
        case (funct3[2:1])
          2'b00:   dec.ctrl = ALU_SUB;   // BEQ/BNE compare via difference
          2'b10:   dec.ctrl = ALU_SLT;   // BLT/BGE
          2'b11:   dec.ctrl = ALU_SLTU;  // BLTU/BGEU
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.d1 = in_rs1_data;
        dec.d2 = imm_i;
      end
      OPC_STORE: begin
        dec.d1 = in_rs1_data;
        dec.d2 = imm_s;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Main + skid buffering
  // ---------------------------------------------------------------------
  issue_t m_data;
  issue_t s_data;
  logic   m_valid;
  logic   s_valid;
  logic   m_valid_next;
  logic   s_valid_next;
  logic   m_load_in;
  logic   m_load_s;
  logic   s_load_in;
  logic   accept;
  logic   m_free;

  assign accept = in_valid & in_ready;
  assign m_free = ~m_valid | out_ready;  // M empty or draining this edge

  // in_ready is ~s_valid, so accept and s_valid are never both high: an
  // occupied S always refills M before any new input is taken.
  always_comb begin
    m_valid_next = m_valid;
    s_valid_next = s_valid;
    m_load_in    = 1'b0;
    m_load_s     = 1'b0;
    s_load_in    = 1'b0;
    if (flush) begin
      m_valid_next = 1'b0;
      s_valid_next = 1'b0;
    end else if (m_free) begin
      if (s_valid) begin
        m_load_s     = 1'b1;
        m_valid_next = 1'b1;
        s_valid_next = 1'b0;
      end else begin
        m_load_in    = accept;
        m_valid_next = accept;
      end
    end else if (accept) begin
      s_load_in    = 1'b1;
      s_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      s_valid  <= 1'b0;
      in_ready <= 1'b1;
      m_data   <= '0;
      s_data   <= '0;
    end else begin
      m_valid  <= m_valid_next;
      s_valid  <= s_valid_next;
      in_ready <= ~s_valid_next;
      if (m_load_s) begin
        m_data <= s_data;
      end else if (m_load_in) begin
        m_data <= dec;
      end
      if (s_load_in) begin
        s_data <= dec;
      end
    end
  end

  assign out_valid   = m_valid;
  assign alu_ctrl    = m_data.ctrl;
  assign alu_datain1 = m_data.d1;
  assign alu_datain2 = m_data.d2;
  assign out_rd      = m_data.rd;
  assign out_wb_en   = m_data.wb_en;
  assign out_branch  = m_data.branch;
  assign out_funct3  = m_data.funct3;
  assign out_illegal = m_data.illegal;

endmodule

// File: doc/alu_issue.md
# alu_issue

ID/EX issue stage feeding the execute-stage ALU. Decodes one RV32I instruction per accepted transfer into an `alu_ctrl` code and the two 32-bit ALU operands, then registers them behind a valid/ready handshake with a one-entry skid buffer. The block sits between register-file read (upstream) and `alu` (downstream). It provides full throughput, a registered `in_ready`, and a synchronous pipeline flush.

## Interface
- No parameters; XLEN fixed at 32. `alu_ctrl` encodings are the `ADD`…`AND` macros from `core_defines.v`.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all held and incoming instructions.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept; registered.
- in_instr  in  32  raw instruction.
- in_pc  in  32  instruction PC.
- in_rs1_data  in  32  rs1 register value.
- in_rs2_data  in  32  rs2 register value.
- out_valid  out  1  issue registers hold a valid op.
- out_ready  in  1  execute stage accepts.
- alu_ctrl  out  4  ALU operation code.
- alu_datain1  out  32  operand 1.
- alu_datain2  out  32  operand 2.
- out_rd  out  5  destination register, `instr[11:7]`.
- out_wb_en  out  1  result written back: OP, OP-IMM, LUI, AUIPC only.
- out_branch  out  1  instruction is a conditional branch.
- out_funct3  out  3  `instr[14:12]`, passed through for branch or memory resolution.
- out_illegal  out  1  opcode/funct combination is unsupported.

## Operation
- Immediates, all sign-extended:
  - I: `instr[31:20]`
  - S: `{instr[31:25], instr[11:7]}`
  - U: `{instr[31:12], 12'b0}`
- OP (0110011): d1 = rs1, d2 = rs2.
  - funct3 000 → ADD, or SUB when funct7 = 0100000.
  - 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR.
  - 101 → SRL, or SRA when funct7 = 0100000.
  - 110 → OR; 111 → AND.
  - funct7 must be 0000000, except 0100000 is allowed with funct3 000/101; otherwise illegal.
- OP-IMM (0010011): d1 = rs1, d2 = I-imm, same funct3 map as OP with no SUB.
  - Shifts (funct3 001/101): d2 = `{27'b0, instr[24:20]}`; `instr[30]` = 1 selects SRAI.
  - `instr[31:25]` must be 0000000, or 0100000 for SRAI; otherwise illegal.
- LUI (0110111): ADD, d1 = 0, d2 = U-imm.
- AUIPC (0010111): ADD, d1 = pc, d2 = U-imm.
- BRANCH (1100011): d1 = rs1, d2 = rs2, out_branch = 1.
  - funct3 000/001 → SUB.
  - 100/101 → SLT.
  - 110/111 → SLTU.
  - 010/011 → illegal.
- LOAD (0000011): ADD, rs1 + I-imm. STORE (0100011): ADD, rs1 + S-imm. wb_en = 0 for both; memory stage handles load writeback.
- Any other opcode: out_illegal = 1, ctrl = ADD, d1 = d2 = 0, wb_en = 0, branch = 0.
- Decode is combinational on the input side; only decoded fields are registered.
- Buffering: main register M (drives outputs) and skid register S.
  - Transfer in: `in_valid & in_ready`. Transfer out: `out_valid & out_ready`.
  - Accept while M is empty or draining → load M.
  - Accept while M is full and stalled → load S.
  - When M drains and S is full → S moves to M.
  - `in_ready <= ~S_valid_next`.

## Timing
- Reset (async assert, sync release):
  - out_valid = 0, S empty, in_ready = 1.
  - All data outputs 0; alu_ctrl = `ADD`.
- Latency: input accepted at edge N → out_valid = 1 after edge N, usable in cycle N+1.
- Throughput: one instruction per cycle while out_ready = 1.
- Stall: outputs held stable while `out_valid & ~out_ready`. One more input is absorbed into S, then in_ready drops on the following edge.
- in_ready rises the cycle after S drains to M.
- Ordering: strict FIFO; no bypass of S.
- flush = 1 at an edge:
  - M and S valid bits are cleared; the instruction accepted that cycle is discarded.
  - in_ready = 1 next cycle. Flush wins over every simultaneous event.
- Reset mid-stall discards M and S immediately.

## Test plan
- Reset: assert rst_n = 0 mid-stream → out_valid = 0, in_ready = 1, alu_ctrl = ADD, operands 0, without waiting for a clock edge.
- Decode sweep:
  - `sub x3,x1,x2` with rs1 = 5, rs2 = 7 → SUB, d1 = 5, d2 = 7, rd = 3, wb_en = 1.
  - `srai x1,x2,4` → SRA, d2 = 4.
  - `addi` imm = 0xFFF → d2 = 0xFFFFFFFF.
  - `auipc` pc = 0x100, imm = 0x12345 → d1 = 0x100, d2 = 0x12345000.
- Branch/illegal:
  - `bltu` → SLTU, branch = 1, funct3 = 110, wb_en = 0.
  - funct3 010 branch → illegal = 1.
  - opcode 0x7F → illegal = 1, operands 0.
- Back-pressure:
  - Stream A, B, C with out_ready = 0 → A held in M, B in S, in_ready = 0 after the edge that accepted B.
  - Raise out_ready → output order A, B, C, no loss or duplication.
- Flush: M and S full with flush = 1 and in_valid = 1 simultaneously → next cycle out_valid = 0, in_ready = 1, and the flushing-cycle input is never output.
- Throughput: 16 back-to-back instructions with out_ready = 1 → 16 outputs in 16 consecutive cycles, first one cycle after first accept.
